// File: rtl/vga_char_tx_if.sv
// rtl/vga_char_tx_if.sv - store-path push side and terminal-facing strobe of the character transmitter
interface vga_char_tx_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          we_i;
    logic [7:0]    data_i;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic [7:0]    current_o;
    logic          writeBusy_o;

    modport master (
        output we_i, data_i,
        input  full_o, empty_o, count_o, current_o, writeBusy_o
    );

    modport slave (
        input  we_i, data_i,
        output full_o, empty_o, count_o, current_o, writeBusy_o
    );
endinterface

// File: rtl/vga_char_tx.sv
// rtl/vga_char_tx.sv - FIFO-buffered byte transmitter paced to the text terminal's column bookkeeping
module vga_char_tx #(
    parameter int DEPTH       = 16,
    parameter int BUSY_CYCLES = 4,
    parameter int GAP_SHORT   = 8,
    parameter int GAP_LONG    = 72,
    parameter int LINE_LAST   = 58
) (
    input  logic         clk,
    input  logic         rst,
    vga_char_tx_if.slave bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int MAX_AB  = (BUSY_CYCLES > GAP_SHORT) ? BUSY_CYCLES : GAP_SHORT;
    localparam int CNT_MAX = (MAX_AB > GAP_LONG) ? MAX_AB : GAP_LONG;
    localparam int CNTW    = $clog2(CNT_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nx;
    logic            full;
    logic            push, pop;
    logic [7:0]      head;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic [7:0]      cur, cur_nx;
    logic            busy, busy_nx;
    logic [5:0]      col, col_nx;
    logic            long_gap, long_nx;

    assign head = mem[rd_ptr];
    assign push = bus.we_i && !full;
    assign pop  = (state == IDLE) && (count != '0);

    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nx;
            full  <= (count_nx == (AW+1)'(DEPTH));
        end
    end

    // Mirror the terminal's cursor so line-advancing bytes get room for its line clean
    always_comb begin
        col_nx  = col;
        long_nx = long_gap;
        if (pop) begin
            if (head == 8'h08) begin
                if (col != '0) col_nx = col - 1'b1;
                long_nx = 1'b0;
            end else if (head == 8'h0A) begin
                col_nx  = '0;
                long_nx = 1'b1;
            end else if (col == 6'(LINE_LAST)) begin
                col_nx  = '0;
                long_nx = 1'b1;
            end else begin
                col_nx  = col + 1'b1;
                long_nx = 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cur_nx   = cur;
        busy_nx  = busy;
        case (state)
            IDLE: begin
                if (pop) begin
                    cur_nx   = head;
                    busy_nx  = 1'b1;
                    cnt_nx   = CNTW'(BUSY_CYCLES - 1);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    busy_nx  = 1'b0;
                    cnt_nx   = long_gap ? CNTW'(GAP_LONG - 1) : CNTW'(GAP_SHORT - 1);
                    state_nx = GAP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur      <= 8'h00;
            busy     <= 1'b0;
            col      <= '0;
            long_gap <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cur      <= cur_nx;
            busy     <= busy_nx;
            col      <= col_nx;
            long_gap <= long_nx;
        end
    end

    assign bus.full_o      = full;
    assign bus.count_o     = count;
    assign bus.empty_o     = (count == '0) && (state == IDLE);
    assign bus.current_o   = cur;
    assign bus.writeBusy_o = busy;
endmodule

// File: tb/tb_vga_char_tx.sv
// tb/tb_vga_char_tx.sv - directed self-checking bench for vga_char_tx
module tb_vga_char_tx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_char_tx_if #(.DEPTH(16)) bus ();

    vga_char_tx #(
        .DEPTH(16), .BUSY_CYCLES(4), .GAP_SHORT(8), .GAP_LONG(72), .LINE_LAST(58)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] byte_q[$];
    int         fall_q[$];
    logic [5:0] col_q[$];
    int         cyc = 0;
    logic       prev_busy = 1'b0;

    // Record each byte at its rising strobe, and the cycle and column at each falling strobe
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.writeBusy_o && !prev_busy) byte_q.push_back(bus.current_o);
        if (!bus.writeBusy_o && prev_busy) begin
            fall_q.push_back(cyc);
            col_q.push_back(dut.col);
        end
        prev_busy = bus.writeBusy_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        byte_q.delete();
        fall_q.delete();
        col_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic push_byte(input logic [7:0] b);
        int guard = 0;
        while (bus.full_o && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) check("push_timeout", 32'd1, 32'd0);
        bus.we_i   = 1'b1;
        bus.data_i = b;
        tick();
        bus.we_i   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!bus.empty_o && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        bus.we_i   = 1'b0;
        bus.data_i = 8'h00;
        tick();
        tick();
        // Reset values
        check("rst_current", 32'(bus.current_o), 32'h00);
        check("rst_busy",    32'(bus.writeBusy_o), 32'd0);
        check("rst_full",    32'(bus.full_o), 32'd0);
        check("rst_empty",   32'(bus.empty_o), 32'd1);
        check("rst_count",   32'(bus.count_o), 32'd0);
        check("rst_col",     32'(dut.col), 32'd0);
        rst_n = 1'b1;
        tick();
        clear_logs();

        // Single byte: latency, strobe width, hold through the gap
        push_byte(8'h41);
        check("t1_count_after_push", 32'(bus.count_o), 32'd1);
        check("t1_not_empty", 32'(bus.empty_o), 32'd0);
        tick();
        check("t1_busy_rise", 32'(bus.writeBusy_o), 32'd1);
        check("t1_current",   32'(bus.current_o), 32'h41);
        check("t1_count_popped", 32'(bus.count_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_busy_hold", 32'(bus.writeBusy_o), 32'd1);
        end
        tick();
        check("t1_busy_fall", 32'(bus.writeBusy_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t1_gap_current", 32'(bus.current_o), 32'h41);
            check("t1_gap_not_empty", 32'(bus.empty_o), 32'd0);
            tick();
        end
        check("t1_empty_after_gap", 32'(bus.empty_o), 32'd1);
        check("t1_col", 32'(dut.col), 32'd1);

        // "AB\nC": short spacing 13, long spacing 77
        clear_logs();
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h0A);
        push_byte(8'h43);
        wait_idle(600);
        check("t2_nbytes", 32'(byte_q.size()), 32'd4);
        check("t2_nfalls", 32'(fall_q.size()), 32'd4);
        if (byte_q.size() == 4 && fall_q.size() == 4) begin
            check("t2_byte0", 32'(byte_q[0]), 32'h41);
            check("t2_byte1", 32'(byte_q[1]), 32'h42);
            check("t2_byte2", 32'(byte_q[2]), 32'h0A);
            check("t2_byte3", 32'(byte_q[3]), 32'h43);
            check("t2_gap_ab",  32'(fall_q[1] - fall_q[0]), 32'd13);
            check("t2_gap_bnl", 32'(fall_q[2] - fall_q[1]), 32'd13);
            check("t2_gap_nl",  32'(fall_q[3] - fall_q[2]), 32'd77);
        end
        check("t2_col", 32'(dut.col), 32'd1);

        // Line wrap at column 58
        do_reset();
        for (int i = 0; i < 59; i++) push_byte(8'h58);
        push_byte(8'h59);
        wait_idle(2000);
        check("t3_nfalls", 32'(fall_q.size()), 32'd60);
        if (fall_q.size() == 60) begin
            check("t3_gap_57", 32'(fall_q[58] - fall_q[57]), 32'd13);
            check("t3_gap_wrap", 32'(fall_q[59] - fall_q[58]), 32'd77);
            check("t3_col_before_wrap", 32'(col_q[57]), 32'd58);
            check("t3_col_after_wrap", 32'(col_q[58]), 32'd0);
            check("t3_last_byte", 32'(byte_q[59]), 32'h59);
        end
        check("t3_col_final", 32'(dut.col), 32'd1);

        // Backspace at column 0
        do_reset();
        push_byte(8'h08);
        push_byte(8'h41);
        wait_idle(300);
        check("t4_nfalls", 32'(fall_q.size()), 32'd2);
        if (fall_q.size() == 2) begin
            check("t4_byte", 32'(byte_q[0]), 32'h08);
            check("t4_col_bs", 32'(col_q[0]), 32'd0);
            check("t4_short_gap", 32'(fall_q[1] - fall_q[0]), 32'd13);
        end
        check("t4_col_final", 32'(dut.col), 32'd1);

        // Fill the FIFO while the transmitter sits in a long gap
        do_reset();
        push_byte(8'h0A);
        for (int i = 0; i < 5; i++) tick();
        check("t5_in_gap", 32'(bus.writeBusy_o), 32'd0);
        for (int i = 0; i < 17; i++) begin
            bus.we_i   = 1'b1;
            bus.data_i = 8'(8'h30 + i);
            tick();
            if (i == 14) check("t5_not_full_15", 32'(bus.full_o), 32'd0);
        end
        bus.we_i = 1'b0;
        check("t5_full", 32'(bus.full_o), 32'd1);
        check("t5_count", 32'(bus.count_o), 32'd16);
        wait_idle(1000);
        check("t5_nbytes", 32'(byte_q.size()), 32'd17);
        if (byte_q.size() == 17) begin
            check("t5_first", 32'(byte_q[1]), 32'h30);
            check("t5_last", 32'(byte_q[16]), 32'h3F);
        end

        // Asynchronous reset mid-strobe
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h61 + i));
        check("t6_busy_before", 32'(bus.writeBusy_o), 32'd1);
        check("t6_count_before", 32'(bus.count_o), 32'd4);
        rst_n = 1'b0;
        #2;
        check("t6_busy_async", 32'(bus.writeBusy_o), 32'd0);
        check("t6_count_async", 32'(bus.count_o), 32'd0);
        check("t6_empty_async", 32'(bus.empty_o), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        push_byte(8'h55);
        tick();
        check("t6_post_busy", 32'(bus.writeBusy_o), 32'd1);
        check("t6_post_current", 32'(bus.current_o), 32'h55);
        wait_idle(200);
        check("t6_post_nbytes", 32'(byte_q.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
